// File: rtl/instr_encoder_pkg.sv
// Shared RISC-V instruction-type definitions: format codes, error codes and the
// field bundle used by both the encode and decode paths.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ErrNone   = 2'd0,
    ErrRange  = 2'd1,
    ErrAlign  = 2'd2,
    ErrFormat = 2'd3
  } err_e;

  typedef struct packed {
    logic [2:0]  format;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // True when imm[31:msb] are all equal, i.e. the value fits a signed field of msb+1 bits.
  function automatic logic sext_ok(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << msb;
    return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Loader-side field bundle and instruction-memory write side of the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_format;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [1:0]        err_code;
  logic              full;

  modport master (
    output in_valid, in_format, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_code, full
  );

  modport slave (
    input  in_valid, in_format, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_code, full
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational legality check and RV32 bit packing of one field bundle.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fields_t     fields,
  output logic [31:0] instr,
  output err_e        err_code
);

  logic [31:0] imm;
  assign imm = fields.imm;

  // Alignment is checked before range so a misaligned, out-of-range value reports alignment.
  always_comb begin
    instr    = '0;
    err_code = ErrNone;
    case (fields.format)
      FmtR: begin
        instr = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
      end
      FmtI: begin
        instr = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        if (!sext_ok(imm, 11)) err_code = ErrRange;
      end
      FmtS: begin
        instr = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
        if (!sext_ok(imm, 11)) err_code = ErrRange;
      end
      FmtB: begin
        instr = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3, imm[4:1], imm[11],
                 fields.opcode};
        if (imm[0])                  err_code = ErrAlign;
        else if (!sext_ok(imm, 12))  err_code = ErrRange;
      end
      FmtU: begin
        instr = {imm[31:12], fields.rd, fields.opcode};
        if (imm[11:0] != 12'h0) err_code = ErrAlign;
      end
      FmtJ: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
        if (imm[0])                  err_code = ErrAlign;
        else if (!sext_ok(imm, 20))  err_code = ErrRange;
      end
      default: err_code = ErrFormat;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Accepts one field bundle at a time, validates and packs it, and emits the word
// with a sequential instruction-memory address until the address space is exhausted.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  instr_encoder_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCheck, StEmit, StFault, StFull} state_e;

  state_e            state_q;
  fields_t           fields_q;
  fields_t           in_fields;
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  err_e              err_code_q;
  logic              full_q;
  logic [31:0]       pack_instr;
  err_e              pack_err;

  assign in_fields = '{
    format: bus.in_format, opcode: bus.in_opcode, rd: bus.in_rd, funct3: bus.in_funct3,
    rs1: bus.in_rs1, rs2: bus.in_rs2, funct7: bus.in_funct7, imm: bus.in_imm
  };

  instr_pack u_pack (
    .fields   (fields_q),
    .instr    (pack_instr),
    .err_code (pack_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      fields_q    <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
      full_q      <= 1'b0;
    end else if (flush) begin
      // Overrides every state; a word pending in EMIT is dropped unwritten.
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
      full_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            fields_q <= in_fields;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          if (pack_err != ErrNone) begin
            err_q      <= 1'b1;
            err_code_q <= pack_err;
            state_q    <= StFault;
          end else begin
            out_instr_q <= pack_instr;
            out_valid_q <= 1'b1;
            state_q     <= StEmit;
          end
        end
        StEmit: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            // Last address written: park in FULL rather than wrapping onto live code.
            if (addr_q == {ADDR_W{1'b1}}) begin
              full_q  <= 1'b1;
              state_q <= StFull;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= StIdle;
            end
          end
        end
        StFault, StFull: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.full      = full_q;

endmodule
